// File: rtl/signal_meter_pkg.sv
// Shared types and helpers for the signal meter (peak-hold + boxcar average).
package signal_meter_pkg;

    localparam int unsigned MAG_W  = 15;
    localparam int unsigned HOLD_W = 16;

    typedef enum logic {
        ST_HOLD  = 1'b0,
        ST_DECAY = 1'b1
    } peak_state_e;

    // Per-sample decay step: peak >> shift, never smaller than 1 so decay always progresses.
    function automatic logic [MAG_W-1:0] decay_step(input logic [MAG_W-1:0] pk,
                                                    input int unsigned      shift);
        logic [MAG_W-1:0] s;
        s = pk >> shift;
        if (s == '0) begin
            s = MAG_W'(1);
        end
        return s;
    endfunction

endpackage

// File: rtl/signal_meter_avg.sv
// Block boxcar averager over 2^AVG_LOG2 valid samples; accumulator sized to never overflow.
module boxcar_avg
    import signal_meter_pkg::*;
#(
    parameter int unsigned DIN_W    = MAG_W,
    parameter int unsigned AVG_LOG2 = 8
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    output logic [DIN_W-1:0] dout,
    output logic             dout_valid
);

    localparam int unsigned ACC_W = DIN_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    sum_d;
    logic [AVG_LOG2-1:0] cnt_q;
    logic [DIN_W-1:0]    dout_q;
    logic                dout_valid_q;

    assign sum_d = acc_q + ACC_W'(din);

    // Accumulate valid samples; on the last sample of a block publish the truncated mean.
    always_ff @(posedge aclk) begin
        if (reset) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            if (din_valid) begin
                cnt_q <= cnt_q + AVG_LOG2'(1);
                if (cnt_q == '1) begin
                    dout_q       <= DIN_W'(sum_d >> AVG_LOG2);
                    acc_q        <= '0;
                    dout_valid_q <= 1'b1;
                end else begin
                    acc_q <= sum_d;
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: rtl/signal_meter.sv
// Signal meter: peak-hold with hold time and linear-exponential decay, plus block average.
// Optional overload detector enabled by defining SIGNAL_METER_OVERLOAD_EN.
module signal_meter
    import signal_meter_pkg::*;
#(
    parameter int unsigned AVG_LOG2     = 8,
    parameter int unsigned HOLD_SAMPLES = 1024,
    parameter int unsigned DECAY_SHIFT  = 4
`ifdef SIGNAL_METER_OVERLOAD_EN
    ,
    parameter logic [15:0] OVL_THRESHOLD = 16'd30000
`endif
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic [15:0]      mag,
    input  logic             mag_valid,
    output logic [MAG_W-1:0] peak,
    output logic             peak_valid,
    output logic [MAG_W-1:0] avg,
    output logic             avg_valid
`ifdef SIGNAL_METER_OVERLOAD_EN
    ,
    output logic             overload,
    output logic [15:0]      ovl_count
`endif
);

    logic [MAG_W-1:0]  mag_clip;
    logic [MAG_W-1:0]  step_w;
    logic [MAG_W-1:0]  peak_dec_d;
    logic [MAG_W-1:0]  peak_q;
    logic              peak_valid_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    peak_state_e       state_q;

    // Negative samples clamp to zero; the sign bit is the only thing dropped otherwise.
    assign mag_clip   = mag[15] ? '0 : mag[MAG_W-1:0];
    assign step_w     = decay_step(peak_q, DECAY_SHIFT);
    assign peak_dec_d = peak_q - step_w;

    // Peak FSM: attack on m >= peak, hold for HOLD_SAMPLES, then decay floored at the input.
    always_ff @(posedge aclk) begin
        if (reset) begin
            peak_q       <= '0;
            peak_valid_q <= 1'b0;
            hold_cnt_q   <= '0;
            state_q      <= ST_DECAY;
        end else begin
            peak_valid_q <= mag_valid;
            if (mag_valid) begin
                if (mag_clip >= peak_q) begin
                    peak_q     <= mag_clip;
                    hold_cnt_q <= HOLD_W'(HOLD_SAMPLES - 1);
                    state_q    <= ST_HOLD;
                end else if (state_q == ST_HOLD) begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end else begin
                        state_q <= ST_DECAY;
                    end
                end else begin
                    peak_q <= (mag_clip > peak_dec_d) ? mag_clip : peak_dec_d;
                end
            end
        end
    end

    assign peak       = peak_q;
    assign peak_valid = peak_valid_q;

    boxcar_avg #(
        .DIN_W    (MAG_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .aclk       (aclk),
        .reset      (reset),
        .din        (mag_clip),
        .din_valid  (mag_valid),
        .dout       (avg),
        .dout_valid (avg_valid)
    );

`ifdef SIGNAL_METER_OVERLOAD_EN
    logic        overload_q;
    logic [15:0] ovl_count_q;
    logic        ovl_hit;

    assign ovl_hit = mag_valid && ({1'b0, mag_clip} >= OVL_THRESHOLD);

    // Overload flag aligned with peak_valid, and a saturating event count.
    always_ff @(posedge aclk) begin
        if (reset) begin
            overload_q  <= 1'b0;
            ovl_count_q <= '0;
        end else begin
            overload_q <= ovl_hit;
            if (ovl_hit && (ovl_count_q != 16'hFFFF)) begin
                ovl_count_q <= ovl_count_q + 16'd1;
            end
        end
    end

    assign overload  = overload_q;
    assign ovl_count = ovl_count_q;
`endif

endmodule

// File: tb/tb_signal_meter.sv
// Scoreboard bench for signal_meter (HOLD_SAMPLES=4, DECAY_SHIFT=2, AVG_LOG2=2).
module tb_signal_meter;

    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned HOLD     = 4;
    localparam int unsigned DSH      = 2;

    logic        aclk = 1'b0;
    logic        reset;
    logic [15:0] mag;
    logic        mag_valid;
    logic [14:0] peak;
    logic        peak_valid;
    logic [14:0] avg;
    logic        avg_valid;
`ifdef SIGNAL_METER_OVERLOAD_EN
    logic        overload;
    logic [15:0] ovl_count;
`endif

    always #5 aclk = ~aclk;

    signal_meter #(
        .AVG_LOG2     (AVG_LOG2),
        .HOLD_SAMPLES (HOLD),
        .DECAY_SHIFT  (DSH)
    ) dut (
        .aclk       (aclk),
        .reset      (reset),
        .mag        (mag),
        .mag_valid  (mag_valid),
        .peak       (peak),
        .peak_valid (peak_valid),
        .avg        (avg),
        .avg_valid  (avg_valid)
`ifdef SIGNAL_METER_OVERLOAD_EN
        ,
        .overload   (overload),
        .ovl_count  (ovl_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    int exp_peak_q[$];
    int exp_avg_q[$];
    bit exp_ovl_q[$];
    bit prev_valid = 1'b0;
    bit avg_due    = 1'b0;

    // Reference model state
    int mp = 0;
    int mh = 0;
    bit mdecay = 1'b1;
    int macc = 0;
    int mcnt = 0;
    int movl_cnt = 0;

    task automatic model_reset();
        mp = 0; mh = 0; mdecay = 1'b1;
        macc = 0; mcnt = 0; movl_cnt = 0;
        exp_peak_q.delete();
        exp_avg_q.delete();
        exp_ovl_q.delete();
        prev_valid = 1'b0;
        avg_due    = 1'b0;
    endtask

    // One clock: compare outputs due from the previous cycle, then drive and predict this cycle.
    task automatic step(input bit v, input int val);
        int m, st, dec, e;
        bit eo;
        @(negedge aclk);
        checks++;
        if (peak_valid !== prev_valid) begin
            failures++;
            $display("FAIL peak_valid_timing got=%0b exp=%0b t=%0t", peak_valid, prev_valid, $time);
        end
        eo = 1'b0;
        if (prev_valid) begin
            e  = exp_peak_q.pop_front();
            eo = exp_ovl_q.pop_front();
            if (peak_valid === 1'b1) begin
                checks++;
                if (peak !== 15'(e)) begin
                    failures++;
                    $display("FAIL peak_value got=%0d exp=%0d t=%0t", peak, e, $time);
                end
            end
        end
        checks++;
        if (avg_valid !== avg_due) begin
            failures++;
            $display("FAIL avg_valid_timing got=%0b exp=%0b t=%0t", avg_valid, avg_due, $time);
        end
        if (avg_due) begin
            e = exp_avg_q.pop_front();
            checks++;
            if (avg !== 15'(e)) begin
                failures++;
                $display("FAIL avg_value got=%0d exp=%0d t=%0t", avg, e, $time);
            end
        end
`ifdef SIGNAL_METER_OVERLOAD_EN
        checks++;
        if (overload !== eo) begin
            failures++;
            $display("FAIL overload_flag got=%0b exp=%0b t=%0t", overload, eo, $time);
        end
`endif

        mag        = 16'(val);
        mag_valid  = v;
        prev_valid = v;
        avg_due    = 1'b0;
        if (v) begin
            m = (val < 0) ? 0 : (val & 32'h7fff);
            if (m >= mp) begin
                mp = m; mh = HOLD - 1; mdecay = 1'b0;
            end else if (!mdecay) begin
                if (mh > 0) mh--;
                else mdecay = 1'b1;
            end else begin
                st = mp >> DSH;
                if (st < 1) st = 1;
                dec = mp - st;
                mp = (m > dec) ? m : dec;
            end
            exp_peak_q.push_back(mp);
            macc += m;
            mcnt++;
            if (mcnt == (1 << AVG_LOG2)) begin
                exp_avg_q.push_back(macc >> AVG_LOG2);
                macc = 0; mcnt = 0; avg_due = 1'b1;
            end
            if (m >= 30000) begin
                exp_ovl_q.push_back(1'b1);
                if (movl_cnt < 65535) movl_cnt++;
            end else begin
                exp_ovl_q.push_back(1'b0);
            end
        end
    endtask

    task automatic test_reset();
        step(0, 0);
        @(negedge aclk);
        reset     = 1'b1;
        mag_valid = 1'b0;
        mag       = '0;
        repeat (3) @(negedge aclk);
        checks++;
        if (peak !== 15'd0 || peak_valid !== 1'b0 || avg !== 15'd0 || avg_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got peak=%0d pv=%0b avg=%0d av=%0b exp all 0",
                     peak, peak_valid, avg, avg_valid);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_first_attack();
        step(1, 1000);
        step(0, 0);
        checks++;
        if (peak !== 15'd1000 || avg !== 15'd0 || avg_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_attack got peak=%0d avg=%0d av=%0b exp peak=1000 avg=0 av=0",
                     peak, avg, avg_valid);
        end
    endtask

    task automatic test_hold_decay();
        for (int i = 0; i < 8; i++) step(1, 0);
        step(0, 0);
        checks++;
        if (peak !== 15'(mp) || peak >= 15'd1000) begin
            failures++;
            $display("FAIL hold_decay_end got=%0d exp=%0d", peak, mp);
        end
    endtask

    task automatic test_floor_reattack();
        int fl;
        fl = mp - 10;
        step(1, fl);
        step(0, 0);
        checks++;
        if (peak !== 15'(fl)) begin
            failures++;
            $display("FAIL decay_floor got=%0d exp=%0d", peak, fl);
        end
        step(1, 0);
        step(1, 500);
        for (int i = 0; i < 3; i++) step(1, 0);
        step(0, 0);
        checks++;
        if (peak !== 15'd500) begin
            failures++;
            $display("FAIL reattack_hold got=%0d exp=500", peak);
        end
    endtask

    task automatic test_average();
        step(1, 100);
        step(1, 200);
        step(0, 0);
        step(0, 0);
        step(1, 300);
        step(1, 401);
        step(0, 0);
        checks++;
        if (avg !== 15'd250 || avg_valid !== 1'b1) begin
            failures++;
            $display("FAIL avg_block got avg=%0d av=%0b exp avg=250 av=1", avg, avg_valid);
        end
        step(0, 0);
        checks++;
        if (avg !== 15'd250 || avg_valid !== 1'b0) begin
            failures++;
            $display("FAIL avg_hold got avg=%0d av=%0b exp avg=250 av=0", avg, avg_valid);
        end
        for (int i = 0; i < 4; i++) step(1, -5);
        step(0, 0);
        checks++;
        if (avg !== 15'd0) begin
            failures++;
            $display("FAIL avg_negative got=%0d exp=0", avg);
        end
    endtask

    task automatic test_reset_mid_block();
        step(1, 1000);
        step(1, 1000);
        test_reset();
        for (int i = 0; i < 4; i++) step(1, 8);
        step(0, 0);
        checks++;
        if (avg !== 15'd8) begin
            failures++;
            $display("FAIL avg_after_reset got=%0d exp=8", avg);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0)
                step(1, int'($urandom_range(0, 30000)) - 4000);
            else
                step(0, 0);
        end
        step(0, 0);
    endtask

`ifdef SIGNAL_METER_OVERLOAD_EN
    task automatic test_overload();
        test_reset();
        step(1, 30000);
        step(1, 29999);
        step(0, 0);
        checks++;
        if (ovl_count !== 16'd1 || overload !== 1'b0) begin
            failures++;
            $display("FAIL ovl_single got cnt=%0d ovl=%0b exp cnt=1 ovl=0", ovl_count, overload);
        end
        for (int i = 0; i < 65536; i++) step(1, 30000);
        step(0, 0);
        checks++;
        if (ovl_count !== 16'hFFFF || ovl_count !== 16'(movl_cnt)) begin
            failures++;
            $display("FAIL ovl_saturate got=%0h exp=ffff", ovl_count);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        mag       = '0;
        mag_valid = 1'b0;
        test_reset();
        test_first_attack();
        test_hold_decay();
        test_floor_reattack();
        test_reset();
        test_average();
        test_reset_mid_block();
        test_back_to_back();
`ifdef SIGNAL_METER_OVERLOAD_EN
        test_overload();
`endif
        step(0, 0);
        checks++;
        if (exp_peak_q.size() != 0 || exp_avg_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got peak_left=%0d avg_left=%0d exp 0",
                     exp_peak_q.size(), exp_avg_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
